// File: rtl/rx_frame_buffer.sv
// Store-and-forward rx frame FIFO: a frame becomes visible to the reader only once it is complete.
// Latency: frame visible 1 cycle after its last byte is accepted; read data 1 cycle after rd_en is accepted.
// Backpressure: no wr ready; bytes that arrive while full (or with 8 frames pending) discard the frame; rd_en stalls reads.

// Generic synchronous FIFO; head is the oldest entry and reads straight from flops.
module sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [1<<AW];
  logic [AW:0]  wr_idx;
  logic [AW:0]  rd_idx;

  assign empty = (wr_idx == rd_idx);
  assign full  = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
  assign head  = mem[rd_idx[AW-1:0]];

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx[AW-1:0]] <= push_dat;
  end

  // index update; push and pop in the same cycle leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push && !full) wr_idx <= wr_idx + 1'b1;
      if (pop && !empty) rd_idx <= rd_idx + 1'b1;
    end
  end
endmodule

module rx_frame_buffer #(
  parameter int          ADDR_W   = 11,
  parameter int          LEN_AW   = 3,
  parameter int unsigned AFULL_TH = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  input  logic        wr_last,
  input  logic        wr_drop,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        frm_avail,
  output logic [15:0] frm_len,
  output logic        almost_full,
  output logic [15:0] drop_cnt
);
  typedef enum logic {S_IDLE, S_BURST} rd_state_t;

  logic [7:0]    mem [1<<ADDR_W];
  logic [ADDR_W:0] wr_ptr;     // speculative write pointer
  logic [ADDR_W:0] wr_commit;  // end of the last committed frame
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] used;
  logic [ADDR_W:0] free_bytes;
  logic [15:0]   cur_len;
  logic          ovf;
  logic          full;
  logic          mem_we;
  logic          frm_end;
  logic          do_commit;
  logic          do_drop;

  logic          lf_full;
  logic          lf_empty;
  logic          lf_pop;
  logic [15:0]   lf_head;

  rd_state_t     state, state_nxt;
  logic [15:0]   rem, rem_nxt;
  logic          issue;
  logic          issue_last;

  // used never exceeds the depth, so its top bit alone means full
  assign used       = wr_ptr - rd_ptr;
  assign full       = used[ADDR_W];
  assign free_bytes = {1'b1, {ADDR_W{1'b0}}} - used;

  assign mem_we    = wr_valid && !full && !ovf;
  assign frm_end   = wr_valid && wr_last;
  // full/ovf cover both an earlier overflow and the final byte itself being refused
  assign do_commit = frm_end && !ovf && !full && !wr_drop && !lf_full;
  assign do_drop   = frm_end && !do_commit;

  // byte RAM write port
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  // write-side pointers: advance per byte, rewind to the last commit on a discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      cur_len   <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (do_drop)     wr_ptr <= wr_commit;
      else if (mem_we) wr_ptr <= wr_ptr + 1'b1;

      if (do_commit) wr_commit <= wr_ptr + 1'b1;

      if (frm_end) begin
        cur_len <= '0;
        ovf     <= 1'b0;
      end else begin
        if (mem_we)               cur_len <= cur_len + 16'd1;
        if (wr_valid && full)     ovf     <= 1'b1;
      end

      if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  sync_fifo #(.W(16), .AW(LEN_AW)) u_len_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (do_commit),
    .push_dat (cur_len + 16'd1),
    .pop      (lf_pop),
    .head     (lf_head),
    .full     (lf_full),
    .empty    (lf_empty)
  );

  assign frm_avail = !lf_empty;
  assign frm_len   = lf_empty ? 16'd0 : lf_head;

  // read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // read FSM: IDLE issues the first byte while loading the length, BURST counts down
  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    issue      = 1'b0;
    issue_last = 1'b0;
    lf_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_en && frm_avail) begin
          issue = 1'b1;
          if (frm_len == 16'd1) begin
            issue_last = 1'b1;
            lf_pop     = 1'b1;
          end else begin
            rem_nxt   = frm_len - 16'd1;
            state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (rd_en) begin
          issue = 1'b1;
          if (rem == 16'd1) begin
            issue_last = 1'b1;
            lf_pop     = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            rem_nxt = rem - 16'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // read pointer and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_last  <= issue_last;
      if (issue) begin
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

  // pause threshold on current free space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (32'(free_bytes) < AFULL_TH);
  end
endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_last, wr_drop, rd_en;
  logic        sel;  // 0: full-size buffer, 1: 64-byte buffer

  logic [7:0]  a_rd_data, s_rd_data;
  logic        a_rd_valid, s_rd_valid, a_rd_last, s_rd_last;
  logic        a_frm_avail, s_frm_avail, a_almost_full, s_almost_full;
  logic [15:0] a_frm_len, s_frm_len, a_drop_cnt, s_drop_cnt;

  logic [7:0]  rd_data;
  logic        rd_valid, rd_last, frm_avail, almost_full;
  logic [15:0] frm_len, drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid & ~sel),
    .wr_last(wr_last), .wr_drop(wr_drop), .rd_en(rd_en & ~sel),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_last(a_rd_last),
    .frm_avail(a_frm_avail), .frm_len(a_frm_len), .almost_full(a_almost_full),
    .drop_cnt(a_drop_cnt)
  );

  rx_frame_buffer #(.ADDR_W(6), .LEN_AW(3), .AFULL_TH(16)) dut_s (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid & sel),
    .wr_last(wr_last), .wr_drop(wr_drop), .rd_en(rd_en & sel),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_last(s_rd_last),
    .frm_avail(s_frm_avail), .frm_len(s_frm_len), .almost_full(s_almost_full),
    .drop_cnt(s_drop_cnt)
  );

  assign rd_data     = sel ? s_rd_data     : a_rd_data;
  assign rd_valid    = sel ? s_rd_valid    : a_rd_valid;
  assign rd_last     = sel ? s_rd_last     : a_rd_last;
  assign frm_avail   = sel ? s_frm_avail   : a_frm_avail;
  assign frm_len     = sel ? s_frm_len     : a_frm_len;
  assign almost_full = sel ? s_almost_full : a_almost_full;
  assign drop_cnt    = sel ? s_drop_cnt    : a_drop_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive one frame; returns on the negedge after the last byte was sampled
  task automatic write_frame(input int len, input logic [7:0] start, input logic drop, input logic expect_ok);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = start + 8'(i);
      wr_last  = (i == len - 1);
      wr_drop  = drop && (i == len - 1);
      if (expect_ok) exp_q.push_back({(i == len - 1), start + 8'(i)});
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_drop  = 1'b0;
  endtask

  // hold rd_en for n cycles and compare each returned beat against the scoreboard
  task automatic read_n(input int n, input logic keep);
    logic [8:0] e;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data",  32'(rd_data),  32'(e[7:0]));
      chk("rd_last",  32'(rd_last),  32'(e[8]));
    end
    if (!keep) rd_en = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_data"},  32'(rd_data),     32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),    32'd0);
    chk({tag, "_rd_last"},  32'(rd_last),     32'd0);
    chk({tag, "_avail"},    32'(frm_avail),   32'd0);
    chk({tag, "_len"},      32'(frm_len),     32'd0);
    chk({tag, "_afull"},    32'(almost_full), 32'd0);
    chk({tag, "_drops"},    32'(drop_cnt),    32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; wr_data = '0; wr_valid = 1'b0;
    wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_afull", 32'(almost_full), 32'd0);

    // single 64-byte frame
    write_frame(64, 8'h00, 1'b0, 1'b1);
    chk("t1_avail", 32'(frm_avail), 32'd1);
    chk("t1_len",   32'(frm_len),   32'd64);
    read_n(64, 1'b0);
    chk("t1_avail_after", 32'(frm_avail), 32'd0);
    @(negedge clk);
    chk("t1_rd_valid_idle", 32'(rd_valid), 32'd0);

    // almost_full boundary: 1600 free is below nothing, 1599 free asserts
    write_frame(448, 8'h11, 1'b0, 1'b1);
    @(negedge clk);
    chk("af_1600_free", 32'(almost_full), 32'd0);
    write_frame(1, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    chk("af_1599_free", 32'(almost_full), 32'd1);
    read_n(449, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("af_drained", 32'(almost_full), 32'd0);

    // back-to-back 60 + 1 byte frames
    write_frame(60, 8'h40, 1'b0, 1'b1);
    write_frame(1,  8'hA5, 1'b0, 1'b1);
    chk("t2_len60", 32'(frm_len), 32'd60);
    read_n(60, 1'b1);
    chk("t2_len1", 32'(frm_len), 32'd1);
    read_n(1, 1'b0);
    chk("t2_avail_after", 32'(frm_avail), 32'd0);

    // errored frame discarded, next frame reuses the space
    write_frame(100, 8'h10, 1'b1, 1'b0);
    chk("t3_avail", 32'(frm_avail), 32'd0);
    chk("t3_drops", 32'(drop_cnt),  32'd1);
    write_frame(64, 8'h80, 1'b0, 1'b1);
    chk("t3_len", 32'(frm_len), 32'd64);
    read_n(64, 1'b0);

    // overflow on the 64-byte buffer
    @(negedge clk);
    sel = 1'b1;
    write_frame(70, 8'h00, 1'b0, 1'b0);
    chk("t4_avail", 32'(frm_avail), 32'd0);
    chk("t4_drops", 32'(drop_cnt),  32'd1);
    @(negedge clk);
    chk("t4_afull_rewound", 32'(almost_full), 32'd0);
    write_frame(10, 8'h30, 1'b0, 1'b1);
    chk("t4_len", 32'(frm_len), 32'd10);
    read_n(10, 1'b0);
    @(negedge clk);
    sel = 1'b0;

    // length FIFO full: ninth frame discarded
    for (int f = 0; f < 8; f++) write_frame(4, 8'(8'h20 + 8'(f * 4)), 1'b0, 1'b1);
    write_frame(4, 8'hF0, 1'b0, 1'b0);
    chk("t5_drops", 32'(drop_cnt), 32'd2);
    chk("t5_len",   32'(frm_len),  32'd4);
    read_n(32, 1'b0);
    chk("t5_avail_after", 32'(frm_avail), 32'd0);

    // reset while a frame is being read and another written
    write_frame(32, 8'h60, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd_en    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'(i);
    end
    chk("t6_reading", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("t6_rst");
    @(negedge clk);
    rd_en = 1'b0; wr_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    write_frame(16, 8'hC0, 1'b0, 1'b1);
    chk("t6_len", 32'(frm_len), 32'd16);
    read_n(16, 1'b0);
    chk("t6_avail_after", 32'(frm_avail), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Single-clock, store-and-forward frame FIFO between the MAC receive interface (byte stream plus last flag) and the transmit controller.
- A frame becomes visible to the read side only after its final byte is written and accepted, so the reader always starts a frame that is complete in memory.
- Frames that are errored or overflowed are discarded by rewinding the write pointer.
- Exports an almost-full flag for the pause-frame controller and a per-frame length for the transmit controller.

Parameters:
- ADDR_W, 11, data RAM address width; depth = 2^ADDR_W bytes (2048).
- LEN_AW, 3, length-FIFO address width; up to 2^LEN_AW = 8 committed frames.
- AFULL_TH, 1600, almost_full asserts when free bytes < AFULL_TH.

Ports:
- clk  in  1  byte clock (MAC rx clock domain)
- rst  in  1  reset, asynchronous, active-high
- wr_data  in  8  received byte
- wr_valid  in  1  wr_data valid this cycle
- wr_last  in  1  qualifies final byte of frame; meaningful only with wr_valid
- wr_drop  in  1  sampled with wr_valid&wr_last; 1 = discard frame (bad FCS/error)
- rd_en  in  1  read request, one byte per cycle
- rd_data  out  8  byte read out
- rd_valid  out  1  rd_data valid
- rd_last  out  1  rd_data is final byte of frame
- frm_avail  out  1  at least one committed frame present
- frm_len  out  16  byte length of head frame; valid while frm_avail
- almost_full  out  1  free space below AFULL_TH
- drop_cnt  out  16  count of discarded frames, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst=1):
  - All pointers and counters cleared; any partial frame is lost.
  - rd_data=0, rd_valid=0, rd_last=0, frm_avail=0, frm_len=0, almost_full=0, drop_cnt=0.
- Pointers are ADDR_W+1 bits: wr_ptr (speculative), wr_commit, rd_ptr. used = wr_ptr - rd_ptr. Data full when used == 2^ADDR_W.
- Write side:
  - On wr_valid with not full and ovf=0: RAM[wr_ptr] <= wr_data, wr_ptr++, cur_len++ (16-bit).
  - On wr_valid while full: set ovf; byte not written.
  - On wr_valid&wr_last, the final byte is handled per the rules above, then:
    - Commit if ovf=0, wr_drop=0, the final byte was written, and the length FIFO is not full. Commit pushes the frame length (including the final byte) into the length FIFO and sets wr_commit to the new wr_ptr.
    - Otherwise rewind wr_ptr to wr_commit and increment drop_cnt (saturating).
    - Either way cur_len <= 0 and ovf <= 0.
  - A 1-byte frame (valid&last in the same cycle) is legal and gives length 1.
  - Full is evaluated against the registered rd_ptr. Space freed by a read becomes usable the next cycle.
- Read side:
  - frm_avail = length FIFO not empty. frm_len = length-FIFO head, registered, stable until that frame's last byte is issued.
  - States:
    - IDLE: rd_en&frm_avail loads rem <= frm_len and goes to BURST. rd_en while frm_avail=0 is ignored (no rd_valid).
    - BURST: each cycle with rd_en issues a RAM read at rd_ptr, rd_ptr++, rem--. When rem reaches 1 and is issued, pop the length FIFO and return to IDLE. rd_en=0 stalls with no read issued.
  - Read latency is 1 cycle: rd_valid/rd_data/rd_last register the cycle after issue. rd_last=1 exactly on the frame's final byte.
  - Back-to-back frames: rd_en held high reads frame N+1 without a gap cycle if it is already committed. The IDLE load takes effect in the same cycle as the first issue.
- Simultaneous read and write are independent. A commit and a pop in the same cycle leave the length-FIFO count unchanged.
- almost_full is registered: (2^ADDR_W - used) < AFULL_TH, updated every cycle.
- Reset mid-read: rd_valid drops immediately and the frame is abandoned.

Test Plan:
- Single frame: write 64 bytes 0x00..0x3F with last on 0x3F → frm_avail=1 one cycle after last, frm_len=64. With rd_en held, rd_data 0x00..0x3F appears on 64 consecutive cycles starting 1 cycle after the first rd_en, rd_last only on 0x3F. frm_avail=0 afterwards.
- Back-to-back: commit frames of 60 and 1 bytes, then hold rd_en → 61 consecutive rd_valid cycles with rd_last on the 60th and 61st beats, and frm_len shows 60 then 1.
- Error drop: 100-byte frame with wr_drop=1 on last → frm_avail stays 0, drop_cnt=1. The following 64-byte frame reads back correctly from the same addresses.
- Overflow: ADDR_W=6 (64 B), write a 70-byte frame → dropped, drop_cnt=1, wr_ptr back at 0. A subsequent 10-byte frame commits with frm_len=10.
- Length FIFO full: commit 8 frames of 4 bytes without reading, write a 9th → 9th dropped, drop_cnt=1. All 8 frames read back intact.
- Reset mid-frame: assert rst after 20 bytes of a write and during a read → all outputs 0 immediately. A fresh 16-byte frame after deassertion reads back exactly.
